// File: rtl/arr_port_arbiter.sv
// Round-robin arbiter with optional lock that shares one single-port,
// synchronous-read array memory between N requesters and returns read data by tag.
module arr_port_arbiter #(
  parameter int N      = 2,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 27,
  parameter int DEPTH  = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_i,
  input  logic [N-1:0]          we_i,
  input  logic [N-1:0]          lock_i,
  input  logic [N*ADDR_W-1:0]   addr_i,
  input  logic [N*DATA_W-1:0]   wdata_i,
  output logic [N-1:0]          gnt_o,
  output logic [N-1:0]          rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  err_o,
  output logic                  mem_wenable_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] addr_a  [N];
  logic [DATA_W-1:0] wdata_a [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign addr_a[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
    assign wdata_a[gi] = wdata_i[gi*DATA_W +: DATA_W];
  end

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             own_vld_q, own_vld_d;
  logic [IDX_W-1:0] own_idx_q, own_idx_d;
  logic             rtag_vld_q, rtag_vld_d;
  logic [IDX_W-1:0] rtag_idx_q, rtag_idx_d;
  logic             err_q, err_d;

  logic             gnt_vld;
  logic [IDX_W-1:0] gnt_idx;
  logic             illegal;
  int               scan_idx;

  // Grant selection: a locked owner that still requests wins, else round-robin from ptr.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    if (!rst) begin
      if (own_vld_q && req_i[own_idx_q]) begin
        gnt_vld = 1'b1;
        gnt_idx = own_idx_q;
      end else begin
        for (int k = 0; k < N; k++) begin
          scan_idx = int'(ptr_q) + k;
          if (scan_idx >= N) scan_idx = scan_idx - N;
          if (!gnt_vld && req_i[scan_idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = IDX_W'(scan_idx);
          end
        end
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (gnt_vld) gnt_o[gnt_idx] = 1'b1;
  end

  assign illegal       = gnt_vld && ({1'b0, addr_a[gnt_idx]} >= DEPTH_L);
  assign mem_addr_o    = addr_a[gnt_idx];
  assign mem_wdata_o   = wdata_a[gnt_idx];
  assign mem_wenable_o = gnt_vld && we_i[gnt_idx] && !illegal;

  always_comb begin
    ptr_d      = ptr_q;
    own_vld_d  = 1'b0;
    own_idx_d  = own_idx_q;
    rtag_vld_d = 1'b0;
    rtag_idx_d = rtag_idx_q;
    err_d      = 1'b0;
    if (gnt_vld) begin
      ptr_d      = (gnt_idx == IDX_W'(N-1)) ? '0 : gnt_idx + 1'b1;
      own_vld_d  = lock_i[gnt_idx];
      own_idx_d  = gnt_idx;
      rtag_vld_d = !we_i[gnt_idx] && !illegal;
      rtag_idx_d = gnt_idx;
      err_d      = illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      own_vld_q  <= 1'b0;
      own_idx_q  <= '0;
      rtag_vld_q <= 1'b0;
      rtag_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ptr_q      <= ptr_d;
      own_vld_q  <= own_vld_d;
      own_idx_q  <= own_idx_d;
      rtag_vld_q <= rtag_vld_d;
      rtag_idx_q <= rtag_idx_d;
      err_q      <= err_d;
    end
  end

  // Masking with rst squashes a response from a read granted just before reset.
  always_comb begin
    rvalid_o = '0;
    if (rtag_vld_q && !rst) rvalid_o[rtag_idx_q] = 1'b1;
  end

  assign err_o   = err_q && !rst;
  assign rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_arr_port_arbiter.sv
// Directed bench for arr_port_arbiter (N=2): stimulus pushes expected responses,
// a negedge monitor pops and compares them against rvalid/rdata/err.
module tb_arr_port_arbiter;

  localparam int N      = 2;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 27;
  localparam int DEPTH  = 1000;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req, we, lock;
  logic [N*ADDR_W-1:0] addr;
  logic [N*DATA_W-1:0] wdata;
  logic [N-1:0]        gnt_o, rvalid_o;
  logic [DATA_W-1:0]   rdata_o;
  logic                err_o;
  logic                mem_wenable_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic [DATA_W-1:0]   mem_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int                due;
    logic [N-1:0]      rvalid;
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

  rsp_t sb[$];

  arr_port_arbiter #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req),
    .we_i          (we),
    .lock_i        (lock),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .gnt_o         (gnt_o),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .err_o         (err_o),
    .mem_wenable_o (mem_wenable_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_val(input int a);
    return (a == 5) ? DATA_W'(-3) : DATA_W'(a * 3 - 1000);
  endfunction

  // Memory macro model: write on edge, registered read; preloaded while in reset.
  logic [DATA_W-1:0] mem [1024];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else if (mem_wenable_o) begin
      mem[mem_addr_o] <= mem_wdata_o;
    end
    mem_rdata <= mem[mem_addr_o];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare any presented response, or an expected one that is due.
  always @(negedge clk) begin
    rsp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("rsp_rvalid", 64'(rvalid_o), 64'(e.rvalid));
      check("rsp_err", 64'(err_o), 64'(e.err));
      if (e.rvalid != '0) check("rsp_rdata", 64'(rdata_o), 64'(e.data));
    end else if (rvalid_o != '0 || err_o) begin
      check("rsp_unexpected", 64'({rvalid_o, err_o}), 64'(0));
    end
  end

  // One cycle of stimulus: drive, check combinational grant/port, queue response.
  task automatic issue(input logic [N-1:0] rq, input logic [N-1:0] wr, input logic [N-1:0] lk,
                       input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                       input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                       input logic [N-1:0] exp_gnt, input logic exp_we,
                       input logic [N-1:0] exp_rv, input logic [DATA_W-1:0] exp_data,
                       input logic exp_err);
    rsp_t e;
    req   = rq;
    we    = wr;
    lock  = lk;
    addr  = {a1, a0};
    wdata = {d1, d0};
    @(negedge clk);
    check("gnt", 64'(gnt_o), 64'(exp_gnt));
    check("mem_we", 64'(mem_wenable_o), 64'(exp_we));
    if (exp_rv != '0 || exp_err) begin
      e.due    = cyc + 1;
      e.rvalid = exp_rv;
      e.err    = exp_err;
      e.data   = exp_data;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    req = 2'b11; we = 2'b11; addr = {10'd2, 10'd1};
    @(negedge clk);
    check("rst_gnt", 64'(gnt_o), 64'(0));
    check("rst_mem_we", 64'(mem_wenable_o), 64'(0));
    check("rst_rvalid", 64'(rvalid_o), 64'(0));
    check("rst_err", 64'(err_o), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0; req = '0; we = '0;

    // Single read of preloaded -3, then an idle cycle.
    issue(2'b01, 2'b00, 2'b00, 10'd5, 10'd0, '0, '0, 2'b01, 1'b0, 2'b01, init_val(5), 1'b0);
    issue(2'b00, 2'b00, 2'b00, 10'd5, 10'd0, '0, '0, 2'b00, 1'b0, 2'b00, '0, 1'b0);
    // Lone req1 read moves ptr back to 0 (wrap from N-1).
    issue(2'b10, 2'b00, 2'b00, 10'd0, 10'd7, '0, '0, 2'b10, 1'b0, 2'b10, init_val(7), 1'b0);

    // Round-robin: both read for 6 cycles.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        issue(2'b11, 2'b00, 2'b00, 10'd10, 10'd20, '0, '0, 2'b01, 1'b0, 2'b01, init_val(10), 1'b0);
      else
        issue(2'b11, 2'b00, 2'b00, 10'd10, 10'd20, '0, '0, 2'b10, 1'b0, 2'b10, init_val(20), 1'b0);
    end

    // Read-after-write at the top legal address.
    issue(2'b01, 2'b01, 2'b00, 10'd999, 10'd0, 27'd1234, '0, 2'b01, 1'b1, 2'b00, '0, 1'b0);
    issue(2'b01, 2'b00, 2'b00, 10'd999, 10'd0, '0, '0, 2'b01, 1'b0, 2'b01, 27'd1234, 1'b0);

    // Lock: req1 keeps the port for 3 writes while req0 waits with a read.
    issue(2'b11, 2'b10, 2'b10, 10'd30, 10'd100, '0, 27'd111, 2'b10, 1'b1, 2'b00, '0, 1'b0);
    issue(2'b11, 2'b10, 2'b10, 10'd30, 10'd101, '0, 27'd222, 2'b10, 1'b1, 2'b00, '0, 1'b0);
    issue(2'b11, 2'b10, 2'b10, 10'd30, 10'd102, '0, 27'd333, 2'b10, 1'b1, 2'b00, '0, 1'b0);
    issue(2'b01, 2'b00, 2'b10, 10'd30, 10'd102, '0, '0, 2'b01, 1'b0, 2'b01, init_val(30), 1'b0);
    issue(2'b01, 2'b00, 2'b00, 10'd100, 10'd0, '0, '0, 2'b01, 1'b0, 2'b01, 27'd111, 1'b0);
    issue(2'b01, 2'b00, 2'b00, 10'd102, 10'd0, '0, '0, 2'b01, 1'b0, 2'b01, 27'd333, 1'b0);

    // Illegal addresses: write to 1000, read from 1023, then a legal read.
    issue(2'b10, 2'b10, 2'b00, 10'd0, 10'd1000, '0, 27'd77, 2'b10, 1'b0, 2'b00, '0, 1'b1);
    issue(2'b10, 2'b00, 2'b00, 10'd0, 10'd1023, '0, '0, 2'b10, 1'b0, 2'b00, '0, 1'b1);
    issue(2'b01, 2'b00, 2'b00, 10'd999, 10'd0, '0, '0, 2'b01, 1'b0, 2'b01, 27'd1234, 1'b0);
    check("mem_1000_unchanged", 64'(mem[1000]), 64'(init_val(1000)));

    // Reset in the cycle after a granted read: no rvalid, ptr back to 0.
    issue(2'b01, 2'b00, 2'b00, 10'd5, 10'd0, '0, '0, 2'b01, 1'b0, 2'b00, '0, 1'b0);
    rst = 1'b1; req = 2'b11; we = 2'b00; addr = {10'd7, 10'd5};
    @(negedge clk);
    check("rst_mid_gnt", 64'(gnt_o), 64'(0));
    check("rst_mid_rvalid", 64'(rvalid_o), 64'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_mid_mem_we", 64'(mem_wenable_o), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(2'b11, 2'b00, 2'b00, 10'd5, 10'd7, '0, '0, 2'b01, 1'b0, 2'b01, init_val(5), 1'b0);
    issue(2'b11, 2'b00, 2'b00, 10'd5, 10'd7, '0, '0, 2'b10, 1'b0, 2'b10, init_val(7), 1'b0);
    issue(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, '0, '0, 2'b00, 1'b0, 2'b00, '0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("pending_rsp", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
